// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports, the shared memory read port and arbiter status.
// The arbiter uses the slave view; requesters/memory model use the master view.
interface mem_arbiter_if #(
    parameter int DATA_W = 16
);
    logic              req0_read;
    logic [DATA_W-1:0] req0_address;
    logic [DATA_W-1:0] req0_value;
    logic              req0_ready;

    logic              req1_read;
    logic [DATA_W-1:0] req1_address;
    logic [DATA_W-1:0] req1_value;
    logic              req1_ready;

    logic [DATA_W-1:0] mem_address;
    logic              mem_read;
    logic [DATA_W-1:0] mem_value;
    logic              mem_ready;

    logic              grant;
    logic              busy;
    logic              timeout_err;

    modport slave (
        input  req0_read, req0_address, req1_read, req1_address,
        input  mem_value, mem_ready,
        output req0_value, req0_ready, req1_value, req1_ready,
        output mem_address, mem_read, grant, busy, timeout_err
    );

    modport master (
        output req0_read, req0_address, req1_read, req1_address,
        output mem_value, mem_ready,
        input  req0_value, req0_ready, req1_value, req1_ready,
        input  mem_address, mem_read, grant, busy, timeout_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory read port between instruction fetch (port 0)
// and data/debug (port 1), with a watchdog that aborts accesses the memory never finishes.
//
//  state   | meaning
//  --------+-----------------------------------------------------------------
//  IDLE    | no access in flight; pick a requester (priority holder on a tie)
//  ACCESS  | mem_read held high for the owner; wait for mem_ready or watchdog
//  RELEASE | access finished; wait for mem_ready to drop before re-arbitrating
module mem_arbiter #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input logic          clock,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t            state, state_nx;
    logic              prio, prio_nx;
    logic [7:0]        timer, timer_nx;
    logic              grant_q, grant_nx;
    logic [DATA_W-1:0] addr_q, addr_nx;
    logic              read_q, read_nx;
    logic [DATA_W-1:0] val0_q, val0_nx;
    logic [DATA_W-1:0] val1_q, val1_nx;
    logic              rdy0_q, rdy0_nx;
    logic              rdy1_q, rdy1_nx;
    logic              terr_q, terr_nx;
    logic              busy_q, busy_nx;

    logic any_req;
    logic sel;
    logic expired;

    assign any_req = bus.req0_read | bus.req1_read;
    // On a tie the priority holder wins; otherwise whichever port is asking.
    assign sel     = (bus.req0_read & bus.req1_read) ? prio : bus.req1_read;
    assign expired = (timer == TIMER_LAST);

    // State and all registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            prio    <= 1'b0;
            timer   <= 8'd0;
            grant_q <= 1'b0;
            addr_q  <= '0;
            read_q  <= 1'b0;
            val0_q  <= '0;
            val1_q  <= '0;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
            terr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            prio    <= prio_nx;
            timer   <= timer_nx;
            grant_q <= grant_nx;
            addr_q  <= addr_nx;
            read_q  <= read_nx;
            val0_q  <= val0_nx;
            val1_q  <= val1_nx;
            rdy0_q  <= rdy0_nx;
            rdy1_q  <= rdy1_nx;
            terr_q  <= terr_nx;
            busy_q  <= busy_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (any_req) state_nx = ACCESS;
            end
            ACCESS: begin
                if (bus.mem_ready || expired) state_nx = RELEASE;
            end
            RELEASE: begin
                if (!bus.mem_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        prio_nx  = prio;
        timer_nx = timer;
        grant_nx = grant_q;
        addr_nx  = addr_q;
        read_nx  = read_q;
        val0_nx  = val0_q;
        val1_nx  = val1_q;
        rdy0_nx  = 1'b0;
        rdy1_nx  = 1'b0;
        terr_nx  = 1'b0;
        busy_nx  = (state_nx != IDLE);
        case (state)
            IDLE: begin
                if (any_req) begin
                    addr_nx  = sel ? bus.req1_address : bus.req0_address;
                    read_nx  = 1'b1;
                    grant_nx = sel;
                    timer_nx = 8'd0;
                end
            end
            ACCESS: begin
                // Data beats the watchdog when both land on the same edge.
                if (bus.mem_ready) begin
                    read_nx = 1'b0;
                    prio_nx = ~grant_q;
                    if (grant_q) begin
                        val1_nx = bus.mem_value;
                        rdy1_nx = 1'b1;
                    end else begin
                        val0_nx = bus.mem_value;
                        rdy0_nx = 1'b1;
                    end
                end else if (expired) begin
                    read_nx = 1'b0;
                    prio_nx = ~grant_q;
                    terr_nx = 1'b1;
                    if (grant_q) begin
                        val1_nx = '0;
                        rdy1_nx = 1'b1;
                    end else begin
                        val0_nx = '0;
                        rdy0_nx = 1'b1;
                    end
                end else begin
                    timer_nx = timer + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign bus.req0_value  = val0_q;
    assign bus.req0_ready  = rdy0_q;
    assign bus.req1_value  = val1_q;
    assign bus.req1_ready  = rdy1_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_read    = read_q;
    assign bus.grant       = grant_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single access, tie-break, round-robin order,
// watchdog abort, mid-access reset and a lingering mem_ready in RELEASE.
module tb_mem_arbiter;
    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   hi;

    always #5 clock = ~clock;

    mem_arbiter_if #(.DATA_W(16)) bus ();

    mem_arbiter #(.DATA_W(16), .TIMEOUT(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input int max_cycles);
        int n = 0;
        while (bus.mem_read !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        check("wait_grant", 16'(bus.mem_read), 16'h1);
    endtask

    initial begin
        reset            = 1'b1;
        bus.req0_read    = 1'b0;
        bus.req0_address = '0;
        bus.req1_read    = 1'b0;
        bus.req1_address = '0;
        bus.mem_value    = '0;
        bus.mem_ready    = 1'b0;
        #12;
        check("rst_mem_read", 16'(bus.mem_read), 16'h0);
        check("rst_busy", 16'(bus.busy), 16'h0);
        check("rst_grant", 16'(bus.grant), 16'h0);
        check("rst_rdy0", 16'(bus.req0_ready), 16'h0);
        check("rst_rdy1", 16'(bus.req1_ready), 16'h0);
        check("rst_terr", 16'(bus.timeout_err), 16'h0);
        check("rst_addr", bus.mem_address, 16'h0000);
        reset = 1'b0;
        tick();

        // 1: single port-0 read, memory answers after 3 cycles
        bus.req0_address = 16'h0004;
        bus.req0_read    = 1'b1;
        tick();
        check("t1_read", 16'(bus.mem_read), 16'h1);
        check("t1_addr", bus.mem_address, 16'h0004);
        check("t1_grant", 16'(bus.grant), 16'h0);
        check("t1_busy", 16'(bus.busy), 16'h1);
        hi = 1;
        repeat (3) begin
            tick();
            if (bus.mem_read === 1'b1) hi++;
        end
        bus.mem_value = 16'h1234;
        bus.mem_ready = 1'b1;
        tick();
        check("t1_read_cycles", 16'(hi), 16'd4);
        check("t1_read_drop", 16'(bus.mem_read), 16'h0);
        check("t1_rdy0", 16'(bus.req0_ready), 16'h1);
        check("t1_val0", bus.req0_value, 16'h1234);
        check("t1_rdy1", 16'(bus.req1_ready), 16'h0);
        check("t1_terr", 16'(bus.timeout_err), 16'h0);
        bus.req0_read = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        check("t1_rdy0_pulse", 16'(bus.req0_ready), 16'h0);
        check("t1_idle", 16'(bus.busy), 16'h0);

        // 2: both requesters from reset, port 0 wins the tie
        reset = 1'b1;
        #2;
        reset = 1'b0;
        bus.req0_address = 16'h0100;
        bus.req1_address = 16'h0200;
        bus.req0_read    = 1'b1;
        bus.req1_read    = 1'b1;
        tick();
        check("t2_grant0", 16'(bus.grant), 16'h0);
        check("t2_addr0", bus.mem_address, 16'h0100);
        bus.mem_value = 16'hAAAA;
        bus.mem_ready = 1'b1;
        tick();
        check("t2_rdy0", 16'(bus.req0_ready), 16'h1);
        check("t2_rdy1_lo", 16'(bus.req1_ready), 16'h0);
        check("t2_val0", bus.req0_value, 16'hAAAA);
        bus.req0_read = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        check("t2_gap_read", 16'(bus.mem_read), 16'h0);
        check("t2_gap_rdy1", 16'(bus.req1_ready), 16'h0);
        tick();
        check("t2_grant1", 16'(bus.grant), 16'h1);
        check("t2_read1", 16'(bus.mem_read), 16'h1);
        check("t2_addr1", bus.mem_address, 16'h0200);
        bus.mem_value = 16'h5555;
        bus.mem_ready = 1'b1;
        tick();
        check("t2_rdy1", 16'(bus.req1_ready), 16'h1);
        check("t2_rdy0_lo", 16'(bus.req0_ready), 16'h0);
        check("t2_val1", bus.req1_value, 16'h5555);
        check("t2_val0_hold", bus.req0_value, 16'hAAAA);
        bus.req1_read = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // 3: both held for six accesses -> strict alternation starting at port 0
        bus.req0_read = 1'b1;
        bus.req1_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_grant(10);
            check("t3_grant", 16'(bus.grant), 16'(i % 2));
            check("t3_addr", bus.mem_address, (i % 2 == 1) ? 16'h0200 : 16'h0100);
            bus.mem_value = 16'h0300 + 16'(i);
            bus.mem_ready = 1'b1;
            tick();
            if (i % 2 == 1) begin
                check("t3_rdy1", 16'(bus.req1_ready), 16'h1);
                check("t3_rdy0_lo", 16'(bus.req0_ready), 16'h0);
                check("t3_val1", bus.req1_value, 16'h0300 + 16'(i));
            end else begin
                check("t3_rdy0", 16'(bus.req0_ready), 16'h1);
                check("t3_rdy1_lo", 16'(bus.req1_ready), 16'h0);
                check("t3_val0", bus.req0_value, 16'h0300 + 16'(i));
            end
            bus.mem_ready = 1'b0;
            tick();
        end
        bus.req0_read = 1'b0;
        bus.req1_read = 1'b0;
        tick();
        check("t3_idle", 16'(bus.busy), 16'h0);

        // 4: port 1 read with a silent memory -> watchdog abort after 8 ACCESS cycles
        bus.req1_address = 16'h0010;
        bus.req1_read    = 1'b1;
        tick();
        check("t4_grant", 16'(bus.grant), 16'h1);
        check("t4_addr", bus.mem_address, 16'h0010);
        hi = 1;
        repeat (7) begin
            tick();
            if (bus.mem_read === 1'b1) hi++;
        end
        check("t4_read_cycles", 16'(hi), 16'd8);
        check("t4_rdy1_early", 16'(bus.req1_ready), 16'h0);
        check("t4_terr_early", 16'(bus.timeout_err), 16'h0);
        tick();
        check("t4_read_drop", 16'(bus.mem_read), 16'h0);
        check("t4_rdy1", 16'(bus.req1_ready), 16'h1);
        check("t4_val1", bus.req1_value, 16'h0000);
        check("t4_terr", 16'(bus.timeout_err), 16'h1);
        check("t4_rdy0_lo", 16'(bus.req0_ready), 16'h0);
        bus.req1_read = 1'b0;
        tick();
        check("t4_terr_pulse", 16'(bus.timeout_err), 16'h0);
        check("t4_rdy1_pulse", 16'(bus.req1_ready), 16'h0);
        check("t4_idle", 16'(bus.busy), 16'h0);

        // 5: reset in the middle of an access, then a fresh port-0 read
        bus.req0_address = 16'h0020;
        bus.req0_read    = 1'b1;
        tick();
        tick();
        check("t5_mid_read", 16'(bus.mem_read), 16'h1);
        reset         = 1'b1;
        bus.req0_read = 1'b0;
        #1;
        check("t5_rst_read", 16'(bus.mem_read), 16'h0);
        check("t5_rst_busy", 16'(bus.busy), 16'h0);
        check("t5_rst_rdy0", 16'(bus.req0_ready), 16'h0);
        check("t5_rst_rdy1", 16'(bus.req1_ready), 16'h0);
        check("t5_rst_val0", bus.req0_value, 16'h0000);
        reset = 1'b0;
        bus.req0_address = 16'h0030;
        bus.req0_read    = 1'b1;
        tick();
        check("t5_read", 16'(bus.mem_read), 16'h1);
        check("t5_addr", bus.mem_address, 16'h0030);
        check("t5_grant", 16'(bus.grant), 16'h0);
        bus.mem_value = 16'hBEEF;
        bus.mem_ready = 1'b1;
        tick();
        check("t5_rdy0", 16'(bus.req0_ready), 16'h1);
        check("t5_val0", bus.req0_value, 16'hBEEF);

        // 6: mem_ready lingers 3 cycles; pending port 1 waits for it to drop
        bus.req0_read    = 1'b0;
        bus.req1_address = 16'h0040;
        bus.req1_read    = 1'b1;
        repeat (3) begin
            tick();
            check("t6_hold_busy", 16'(bus.busy), 16'h1);
            check("t6_hold_read", 16'(bus.mem_read), 16'h0);
            check("t6_hold_rdy0", 16'(bus.req0_ready), 16'h0);
        end
        bus.mem_ready = 1'b0;
        tick();
        check("t6_idle_read", 16'(bus.mem_read), 16'h0);
        tick();
        check("t6_read", 16'(bus.mem_read), 16'h1);
        check("t6_grant", 16'(bus.grant), 16'h1);
        check("t6_addr", bus.mem_address, 16'h0040);
        bus.mem_value = 16'h4444;
        bus.mem_ready = 1'b1;
        tick();
        check("t6_rdy1", 16'(bus.req1_ready), 16'h1);
        check("t6_val1", bus.req1_value, 16'h4444);
        bus.req1_read = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        tick();
        check("t6_idle", 16'(bus.busy), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
